// File: rtl/wb_mon_pkg.sv
// Shared definitions for the Wishbone B4 pipelined protocol monitor:
// violation bit indices, FSM encoding and first-violation encoder.
package wb_mon_pkg;

    localparam int unsigned VIOL_W           = 9;
    localparam int unsigned V_STB_NOCYC      = 0;
    localparam int unsigned V_STALL_UNSTABLE = 1;
    localparam int unsigned V_WR_NOSEL       = 2;
    localparam int unsigned V_RSP_NOCYC      = 3;
    localparam int unsigned V_RSP_NOREQ      = 4;
    localparam int unsigned V_ACK_ERR        = 5;
    localparam int unsigned V_OVERFLOW       = 6;
    localparam int unsigned V_STALL_TMO      = 7;
    localparam int unsigned V_ACK_TMO        = 8;

    localparam logic [3:0] FIRST_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT
    } state_t;

    // Lowest set index wins; FIRST_NONE when nothing is set.
    function automatic logic [3:0] first_index(input logic [VIOL_W-1:0] v);
        logic [3:0] idx;
        idx = FIRST_NONE;
        for (int i = int'(VIOL_W) - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_mon_timer.sv
// Consecutive-cycle timer: pulses expired once per episode when run has
// been high for LIMIT consecutive cycles.
module wb_mon_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Saturating at LIMIT keeps the pulse to a single cycle per episode.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr || !run) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = run && !clr && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_pipe_protocol_monitor.sv
// Passive Wishbone B4 pipelined link monitor: sticky violation flags,
// first-violation code, IRQ, outstanding depth and transaction counters.
module wb_pipe_protocol_monitor
    import wb_mon_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ADR_W           = 32,
    parameter int unsigned SEL_W           = DATA_W / 8,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned MAX_STALL       = 16,
    parameter int unsigned MAX_ACK_DELAY   = 32
) (
    input  logic                                     CLK,
    input  logic                                     RST_N,
    input  logic                                     CYC_O,
    input  logic                                     STB_O,
    input  logic                                     WE_O,
    input  logic [ADR_W-1:0]                         ADR_O,
    input  logic [SEL_W-1:0]                         SEL_O,
    input  logic [DATA_W-1:0]                        DAT_O,
    input  logic                                     STALL_I,
    input  logic                                     ACK_I,
    input  logic                                     ERR_I,
    input  logic                                     clr,
    output logic [VIOL_W-1:0]                        viol,
    output logic [3:0]                               first_viol,
    output logic                                     irq,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic [31:0]                              xact_count,
    output logic [15:0]                              err_count
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic              req, rsp, stall_now, wait_now;
    logic              stall_exp, ack_exp;
    logic              prev_cyc, prev_stall, prev_we;
    logic [ADR_W-1:0]  prev_adr;
    logic [SEL_W-1:0]  prev_sel;
    logic [DATA_W-1:0] prev_dat;
    logic [VIOL_W-1:0] viol_new, viol_next;
    logic [3:0]        first_next;
    logic [OUT_W-1:0]  out_next;
    state_t            state_q, state_d;
    logic              xact_inc;

    assign req       = CYC_O && STB_O && !STALL_I;
    assign rsp       = ACK_I || ERR_I;
    assign stall_now = CYC_O && STB_O && STALL_I;
    assign wait_now  = CYC_O && !STB_O && !rsp && (outstanding != '0);

    if (MAX_STALL > 0) begin : g_stall_tmr
        wb_mon_timer #(.LIMIT(MAX_STALL)) u_stall_tmr (
            .CLK(CLK), .RST_N(RST_N), .run(stall_now), .clr(!CYC_O), .expired(stall_exp)
        );
    end else begin : g_no_stall_tmr
        assign stall_exp = 1'b0;
    end

    if (MAX_ACK_DELAY > 0) begin : g_ack_tmr
        wb_mon_timer #(.LIMIT(MAX_ACK_DELAY)) u_ack_tmr (
            .CLK(CLK), .RST_N(RST_N), .run(wait_now), .clr(!CYC_O), .expired(ack_exp)
        );
    end else begin : g_no_ack_tmr
        assign ack_exp = 1'b0;
    end

    // Per-cycle protocol checks.
    always_comb begin
        viol_new = '0;
        viol_new[V_STB_NOCYC]      = STB_O && !CYC_O;
        viol_new[V_STALL_UNSTABLE] = prev_stall && (!STB_O || (ADR_O != prev_adr) ||
                                     (SEL_O != prev_sel) || (WE_O != prev_we) ||
                                     (WE_O && (DAT_O != prev_dat)));
        viol_new[V_WR_NOSEL]       = STB_O && WE_O && (SEL_O == '0);
        viol_new[V_RSP_NOCYC]      = rsp && !prev_cyc;
        viol_new[V_RSP_NOREQ]      = rsp && (outstanding == '0) && !req;
        viol_new[V_ACK_ERR]        = ACK_I && ERR_I;
        viol_new[V_OVERFLOW]       = req && (outstanding == OUT_MAX);
        viol_new[V_STALL_TMO]      = stall_exp;
        viol_new[V_ACK_TMO]        = ack_exp || (!CYC_O && (outstanding != '0));
    end

    // Sticky state; a violation coincident with clr takes precedence.
    always_comb begin
        viol_next  = clr ? viol_new : (viol | viol_new);
        first_next = clr ? FIRST_NONE : first_viol;
        if ((viol_new != '0) && (clr || (viol == '0))) begin
            first_next = first_index(viol_new);
        end
    end

    always_comb begin
        out_next = outstanding;
        if (!CYC_O) begin
            out_next = '0;
        end else if (req && !rsp && (outstanding != OUT_MAX)) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!req && rsp && (outstanding != '0)) begin
            out_next = outstanding - OUT_W'(1);
        end
    end

    // Bus-cycle FSM next state.
    always_comb begin
        state_d  = state_q;
        xact_inc = 1'b0;
        case (state_q)
            IDLE:   if (CYC_O) state_d = ACTIVE;
            ACTIVE: if (!CYC_O) state_d = IDLE;
                    else if (!STB_O && (outstanding != '0)) state_d = WAIT;
            WAIT:   if (!CYC_O) state_d = IDLE;
                    else if (STB_O) state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && !CYC_O && (outstanding == '0)) xact_inc = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            viol        <= '0;
            first_viol  <= FIRST_NONE;
            irq         <= 1'b0;
            outstanding <= '0;
            xact_count  <= '0;
            err_count   <= '0;
            prev_cyc    <= 1'b0;
            prev_stall  <= 1'b0;
            prev_we     <= 1'b0;
            prev_adr    <= '0;
            prev_sel    <= '0;
            prev_dat    <= '0;
        end else begin
            state_q     <= state_d;
            viol        <= viol_next;
            first_viol  <= first_next;
            irq         <= |viol_next;
            outstanding <= out_next;
            if (xact_inc && (xact_count != '1)) xact_count <= xact_count + 32'd1;
            if (ERR_I && (err_count != '1)) err_count <= err_count + 16'd1;
            prev_cyc    <= CYC_O;
            prev_stall  <= stall_now;
            prev_we     <= WE_O;
            prev_adr    <= ADR_O;
            prev_sel    <= SEL_O;
            prev_dat    <= DAT_O;
        end
    end

endmodule

// File: tb/tb_wb_pipe_protocol_monitor.sv
// Scoreboard bench for wb_pipe_protocol_monitor: directed scenarios plus
// random traffic against a rule-level reference model.
module tb_wb_pipe_protocol_monitor;

    localparam int MAX_OUT   = 8;
    localparam int MAX_STL   = 16;
    localparam int MAX_ACK   = 32;

    logic        CLK, RST_N;
    logic        CYC_O, STB_O, WE_O, STALL_I, ACK_I, ERR_I, clr;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic [8:0]  viol;
    logic [3:0]  first_viol;
    logic        irq;
    logic [3:0]  outstanding;
    logic [31:0] xact_count;
    logic [15:0] err_count;

    wb_pipe_protocol_monitor #(
        .DATA_W(32), .ADR_W(32), .SEL_W(4), .MAX_OUTSTANDING(MAX_OUT),
        .MAX_STALL(MAX_STL), .MAX_ACK_DELAY(MAX_ACK)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .SEL_O(SEL_O), .DAT_O(DAT_O), .STALL_I(STALL_I),
        .ACK_I(ACK_I), .ERR_I(ERR_I), .clr(clr), .viol(viol),
        .first_viol(first_viol), .irq(irq), .outstanding(outstanding),
        .xact_count(xact_count), .err_count(err_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [8:0]  viol;
        logic [3:0]  first;
        logic        irq;
        logic [3:0]  outst;
        logic [31:0] xact;
        logic [15:0] err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, kept as plain integers and flags.
    int          m_out, m_xact, m_err, stall_run, wait_run;
    bit [8:0]    m_viol;
    bit [3:0]    m_first;
    bit          p_cyc, p_stall, p_we;
    bit [31:0]   p_adr, p_dat;
    bit [3:0]    p_sel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [8:0] v);
        for (int i = 0; i < 9; i++) if (v[i]) return i;
        return 15;
    endfunction

    task automatic model_reset();
        m_out = 0; m_xact = 0; m_err = 0; stall_run = 0; wait_run = 0;
        m_viol = '0; m_first = 4'hF;
        p_cyc = 0; p_stall = 0; p_we = 0; p_adr = '0; p_dat = '0; p_sel = '0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit       req, rsp;
        bit [8:0] nv;
        int       nxt;
        exp_t     e;
        if (!RST_N) begin
            model_reset();
        end else begin
            req = CYC_O && STB_O && !STALL_I;
            rsp = ACK_I || ERR_I;
            nv = '0;
            nv[0] = STB_O && !CYC_O;
            nv[1] = p_stall && (!STB_O || ADR_O != p_adr || SEL_O != p_sel ||
                    WE_O != p_we || (WE_O && DAT_O != p_dat));
            nv[2] = STB_O && WE_O && SEL_O == 4'h0;
            nv[3] = rsp && !p_cyc;
            nv[4] = rsp && m_out == 0 && !req;
            nv[5] = ACK_I && ERR_I;
            nv[6] = req && m_out == MAX_OUT;
            if (CYC_O && STB_O && STALL_I) stall_run++; else stall_run = 0;
            nv[7] = (stall_run == MAX_STL);
            if (CYC_O && !STB_O && !rsp && m_out > 0) wait_run++; else wait_run = 0;
            nv[8] = (wait_run == MAX_ACK) || (!CYC_O && m_out > 0);
            if (p_cyc && !CYC_O && m_out == 0) m_xact++;
            if (ERR_I && m_err < 65535) m_err++;
            nxt = m_out + int'(req) - int'(rsp);
            if (nxt < 0) nxt = 0;
            if (nxt > MAX_OUT) nxt = MAX_OUT;
            if (!CYC_O) nxt = 0;
            m_out = nxt;
            if (nv != 0 && (clr || m_viol == 0)) m_first = 4'(lowest(nv));
            else if (clr) m_first = 4'hF;
            m_viol = clr ? nv : (m_viol | nv);
            p_cyc = CYC_O; p_stall = CYC_O && STB_O && STALL_I;
            p_adr = ADR_O; p_sel = SEL_O; p_we = WE_O; p_dat = DAT_O;
        end
        e.viol = m_viol; e.first = m_first; e.irq = (m_viol != 0);
        e.outst = 4'(m_out); e.xact = 32'(m_xact); e.err = 16'(m_err);
        sb.push_back(e);
    endtask

    // Inputs are set at a falling edge; the expectation applies after the next rising edge.
    task automatic tick();
        model_step();
        @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_bus();
        CYC_O = 0; STB_O = 0; WE_O = 0; ADR_O = '0; SEL_O = '0; DAT_O = '0;
        STALL_I = 0; ACK_I = 0; ERR_I = 0; clr = 0;
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("viol",        64'(viol),        64'(e.viol));
            chk("first_viol",  64'(first_viol),  64'(e.first));
            chk("irq",         64'(irq),         64'(e.irq));
            chk("outstanding", 64'(outstanding), 64'(e.outst));
            chk("xact_count",  64'(xact_count),  64'(e.xact));
            chk("err_count",   64'(err_count),   64'(e.err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_bus();
        RST_N = 0;
        model_reset();
        ticks(2);
        RST_N = 1;
        ticks(2);

        // Single read with ACK two cycles after the request.
        CYC_O = 1; STB_O = 1; ADR_O = 32'h10; tick();
        STB_O = 0; tick();
        ACK_I = 1; tick();
        ACK_I = 0; CYC_O = 0; tick();
        ticks(2);

        // Eight pipelined writes, each acknowledged on the following cycle.
        CYC_O = 1; STB_O = 1; WE_O = 1; SEL_O = 4'hF;
        for (int i = 0; i < 8; i++) begin
            ADR_O = 32'(i * 4); DAT_O = 32'hA000 + 32'(i); ACK_I = (i > 0); tick();
        end
        STB_O = 0; WE_O = 0; ACK_I = 1; tick();
        idle_bus(); tick(); tick();

        // Nine writes with no ACK: overflow, then abort on CYC drop.
        CYC_O = 1; STB_O = 1; WE_O = 1; SEL_O = 4'hF;
        for (int i = 0; i < 9; i++) begin
            ADR_O = 32'(i * 4); tick();
        end
        idle_bus(); tick();
        clr = 1; tick(); clr = 0; tick();

        // Address changes while stalled.
        CYC_O = 1; STB_O = 1; STALL_I = 1; ADR_O = 32'h100; tick();
        ADR_O = 32'h104; tick();
        STALL_I = 0; tick();
        STB_O = 0; ACK_I = 1; tick();
        idle_bus(); tick();
        clr = 1; tick(); clr = 0; tick();

        // Long stall, then a withheld ACK.
        CYC_O = 1; STB_O = 1; STALL_I = 1; ADR_O = 32'h200; ticks(18);
        STALL_I = 0; tick();
        STB_O = 0; ticks(34);
        ACK_I = 1; tick();
        idle_bus(); tick();
        clr = 1; tick(); clr = 0; tick();

        // ACK and ERR together with nothing outstanding.
        CYC_O = 1; tick();
        ACK_I = 1; ERR_I = 1; tick();
        idle_bus(); tick();
        clr = 1; tick(); clr = 0; tick();

        // Violation coincident with clr.
        STB_O = 1; tick();
        STB_O = 0; clr = 1; STB_O = 1; tick();
        idle_bus(); clr = 1; tick(); clr = 0; tick();

        // Reset mid-burst with three requests outstanding.
        CYC_O = 1; STB_O = 1; ADR_O = 32'h300; ticks(3);
        RST_N = 0;
        #1;
        chk("async_rst_viol",  64'(viol),        64'h0);
        chk("async_rst_first", 64'(first_viol),  64'hF);
        chk("async_rst_irq",   64'(irq),         64'h0);
        chk("async_rst_out",   64'(outstanding), 64'h0);
        chk("async_rst_xact",  64'(xact_count),  64'h0);
        chk("async_rst_err",   64'(err_count),   64'h0);
        idle_bus();
        tick();
        RST_N = 1; ticks(3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            CYC_O   = ($urandom % 12) != 0;
            STB_O   = ($urandom % 2) == 0;
            WE_O    = ($urandom % 2) == 0;
            ADR_O   = 32'h100 + 32'(4 * ($urandom % 2));
            SEL_O   = (($urandom % 10) == 0) ? 4'h0 : 4'hF;
            DAT_O   = 32'($urandom % 3);
            STALL_I = ($urandom % 3) == 0;
            ACK_I   = ($urandom % 3) == 0;
            ERR_I   = ($urandom % 12) == 0;
            clr     = ($urandom % 10) == 0;
            tick();
        end
        idle_bus(); ticks(3);

        @(posedge CLK);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_pipe_protocol_monitor.md
Name: wb_pipe_protocol_monitor

Overview:
- Synthesizable, parametrised Wishbone B4 pipelined bus protocol monitor that sits passively on one master/slave link.
- Successor to the formal-only master checker: generalised data/address width, ERR support, outstanding-depth tracking, stall and ACK timeouts.
- Reports violations as sticky flags, a first-violation code and an IRQ, so the same checks run in silicon, emulation and simulation.
- Never drives the bus.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8.
- ADR_W, 32, address width.
- SEL_W, DATA_W/8, byte-select width.
- MAX_OUTSTANDING, 8, maximum accepted-but-unanswered requests; must be ≥1.
- MAX_STALL, 16, maximum consecutive STB&&STALL cycles; 0 disables the check.
- MAX_ACK_DELAY, 32, maximum consecutive wait cycles (CYC, !STB, no response, outstanding>0); 0 disables the check.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- CYC_O  in  1  master cycle
- STB_O  in  1  master strobe
- WE_O  in  1  master write enable
- ADR_O  in  ADR_W  master address
- SEL_O  in  SEL_W  master byte selects
- DAT_O  in  DATA_W  master write data
- STALL_I  in  1  slave stall
- ACK_I  in  1  slave acknowledge
- ERR_I  in  1  slave error response
- clr  in  1  clears sticky violation state
- viol  out  9  sticky violation bits
- first_viol  out  4  index of first violation; 4'hF = none
- irq  out  1  high when viol != 0
- outstanding  out  clog2(MAX_OUTSTANDING+1)  current outstanding count
- xact_count  out  32  completed bus cycles, saturating
- err_count  out  16  ERR responses received, saturating

Behaviour:
- Reset (async, RST_N low): viol=0, first_viol=4'hF, irq=0, outstanding=0, counters=0, FSM=IDLE, all history registers=0.
- Derived signals, per cycle:
  - req = CYC_O&&STB_O&&!STALL_I
  - rsp = ACK_I||ERR_I
- Outstanding counter:
  - next = cur + req − rsp.
  - Cleared when CYC_O low.
  - Saturates at 0 and at MAX_OUTSTANDING.
- FSM:
  - IDLE→ACTIVE on CYC_O.
  - ACTIVE→WAIT when CYC_O && !STB_O && outstanding>0.
  - WAIT→ACTIVE on STB_O.
  - Any state→IDLE when CYC_O low.
  - Each ACTIVE/WAIT→IDLE transition with outstanding==0 increments xact_count.
- Violations are detected combinationally in cycle N; the sticky bit is set and visible at N+1. Bit indices:
  - 0 STB_O without CYC_O.
  - 1 stall instability: previous cycle had CYC&&STB&&STALL, and this cycle STB dropped, or ADR/SEL/WE changed, or DAT changed when WE=1.
  - 2 write strobe (STB&&WE) with SEL_O==0.
  - 3 response while previous-cycle CYC_O was low.
  - 4 response with outstanding==0 and no same-cycle req.
  - 5 ACK_I and ERR_I asserted together.
  - 6 req accepted while outstanding==MAX_OUTSTANDING.
  - 7 stall timeout: stall counter reaches MAX_STALL.
  - 8 ACK timeout: wait counter reaches MAX_ACK_DELAY, or CYC_O dropped with outstanding>0 (abort).
- Checks 3 and 4 apply to ERR_I exactly as to ACK_I; ERR also increments err_count and decrements outstanding.
- first_viol latches the lowest-index bit set in the first cycle any violation occurs; it holds until clr.
- clr clears viol and first_viol next cycle; a violation in the same cycle as clr wins (bit set, first_viol = new index).
- Stall and wait timers:
  - Each resets to 0 when its condition deasserts and when CYC_O is low.
  - Each saturates at its limit, so the violation fires once per episode.
- irq is registered: irq = |viol_next.
- All counters saturate; no wrap-around.
- The monitor never asserts any bus signal.

Decomposition:
- Package wb_mon_pkg:
  - violation index localparams V_STB_NOCYC..V_ACK_TMO and VIOL_W=9.
  - FIRST_NONE=4'hF.
  - FSM enum state_t {IDLE, ACTIVE, WAIT}.
  - priority-encode function for first_viol.
- Sub-module wb_mon_timer (params LIMIT, width clog2(LIMIT+1); ports CLK, RST_N, run, clr, expired), instantiated twice for the stall and ACK-delay timers.
  - Generated away when LIMIT=0.

Test Plan:
- Single read (CYC/STB 1 cycle, no stall, ACK 2 cycles later, CYC drops) → viol=0, outstanding 1→0, xact_count=1.
- 8 back-to-back pipelined writes, SEL=4'hF, ACK on each following cycle, MAX_OUTSTANDING=8 → viol=0; 9th write before any ACK → viol[6]=1, first_viol=6, irq=1.
- Stalled request where ADR changes from 0x100 to 0x104 under STALL → viol[1]=1 one cycle later; clr → viol=0, first_viol=4'hF.
- STALL held 16 cycles with MAX_STALL=16 → viol[7] set exactly once; ACK withheld 32 cycles → viol[8]=1.
- ACK and ERR asserted together, plus a spurious ACK with outstanding=0 in the same cycle → viol[4] and viol[5] set, first_viol=4.
- Reset asserted mid-burst with outstanding=3 → all outputs 0 immediately (first_viol=4'hF); no violations after reset release.
